// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default widths and the
// Gray-code helper used by both pointer blocks.
package fifo_pkg;

  localparam int FIFO_ADDRSIZE = 5;
  localparam int FIFO_DATASIZE = 8;

  // Callers cast to their pointer width; the
  // upper bits of the result are simply dropped.
  function automatic logic [31:0] bin2gray(
    input logic [31:0] b
  );
    return (b >> 1) ^ b;
  endfunction

endpackage

// File: rtl/empty_sync.sv
// Two-flop empty pair: set at once by a low aempty_n,
// cleared only after two consecutive high samples.
// Ports: rclk, rrst, aempty_n in; rempty out.
module empty_sync (
  input  logic rclk,
  input  logic rrst,
  input  logic aempty_n,
  output logic rempty
);

  logic rempty2;

  always_ff @(posedge rclk) begin
    if (rrst || !aempty_n) begin
      rempty  <= 1'b1;
      rempty2 <= 1'b1;
    end else begin
      rempty  <= rempty2;
      rempty2 <= 1'b0;
    end
  end

endmodule

// File: rtl/rptr_empty_fwft.sv
// Read-side FIFO controller: Gray read pointer, empty
// flag and a first-word-fall-through output register.
// Ports: rclk/rrst; aempty_n from async_cmp; rptr to
// async_cmp; raddr/mem_rdata to fifomem; rempty;
// rdata/rvalid/rready consumer handshake.
module rptr_empty_fwft
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE = FIFO_ADDRSIZE,
  parameter int DATASIZE = FIFO_DATASIZE
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                aempty_n,
  output logic [ADDRSIZE-1:0] rptr,
  output logic [ADDRSIZE-1:0] raddr,
  input  logic [DATASIZE-1:0] mem_rdata,
  output logic                rempty,
  output logic [DATASIZE-1:0] rdata,
  output logic                rvalid,
  input  logic                rready
);

  logic [ADDRSIZE-1:0] rbin;
  logic [ADDRSIZE-1:0] rbnext;
  logic                pop;

  empty_sync u_empty_sync (
    .rclk     (rclk),
    .rrst     (rrst),
    .aempty_n (aempty_n),
    .rempty   (rempty)
  );

  // aempty_n also gates pop directly: rempty lags a
  // falling aempty_n by one edge.
  assign pop    = ~rempty & aempty_n
                & (~rvalid | rready);
  assign rbnext = rbin + ADDRSIZE'(1);
  assign raddr  = rbin;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin   <= '0;
      rptr   <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
    end else if (pop) begin
      rbin   <= rbnext;
      rptr   <= ADDRSIZE'(bin2gray(32'(rbnext)));
      rdata  <= mem_rdata;
      rvalid <= 1'b1;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rptr_empty_fwft.sv
// Randomized bench for rptr_empty_fwft against a
// count-based reference model.
module tb_rptr_empty_fwft;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rrst = 1'b1;
  logic          aempty_n = 1'b0;
  logic          rready = 1'b0;
  logic [AW-1:0] rptr;
  logic [AW-1:0] raddr;
  logic [DW-1:0] mem_rdata;
  logic          rempty;
  logic [DW-1:0] rdata;
  logic          rvalid;

  logic [DW-1:0] mem [DEPTH];

  int n_chk = 0;
  int n_bad = 0;

  // reference model state
  int          e_ptr = 0;
  int          hi_run = 0;
  bit          e_valid = 0;
  logic [DW-1:0] e_data = '0;
  logic [AW-1:0] prev_rptr = '0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[raddr];

  rptr_empty_fwft #(
    .ADDRSIZE (AW),
    .DATASIZE (DW)
  ) dut (
    .rclk      (clk),
    .rrst      (rrst),
    .aempty_n  (aempty_n),
    .rptr      (rptr),
    .raddr     (raddr),
    .mem_rdata (mem_rdata),
    .rempty    (rempty),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .rready    (rready)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  function automatic int gray(input int n);
    return n ^ (n >> 1);
  endfunction

  task automatic step(
    input bit rst,
    input bit ae,
    input bit rdy
  );
    bit m_empty;
    bit m_pop;
    @(negedge clk);
    rrst     = rst;
    aempty_n = ae;
    rready   = rdy;
    m_empty  = (hi_run < 2);
    m_pop    = !rst && !m_empty && ae
             && (!e_valid || rdy);
    prev_rptr = rptr;
    @(posedge clk);
    #1;
    if (rst) begin
      e_ptr   = 0;
      hi_run  = 0;
      e_valid = 0;
      e_data  = '0;
    end else begin
      hi_run = ae ? hi_run + 1 : 0;
      if (m_pop) begin
        e_data  = mem[e_ptr];
        e_valid = 1;
        // slot freed: the writer refills it
        mem[e_ptr] = DW'($urandom);
        e_ptr = (e_ptr + 1) % DEPTH;
      end else if (e_valid && rdy) begin
        e_valid = 0;
      end
    end
    chk("rempty", 32'(rempty), 32'(hi_run < 2));
    chk("rvalid", 32'(rvalid), 32'(e_valid));
    chk("rdata", 32'(rdata), 32'(e_data));
    chk("raddr", 32'(raddr), 32'(e_ptr));
    chk("rptr", 32'(rptr), 32'(gray(e_ptr)));
    if (m_pop && !rst)
      chk("gray1bit",
          32'($countones(rptr ^ prev_rptr)), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++)
      mem[i] = (i < 8) ? DW'(8'h10 + i)
                       : DW'($urandom);
    // reset held while aempty_n toggles
    step(1, 0, 0);
    step(1, 1, 1);
    step(1, 0, 1);
    // empty release with rready low
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    // back-pressure then stream past the wrap
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    for (int i = 0; i < 45; i++) step(0, 1, 1);
    // empty hit mid-stream
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 1, 1);
    // reset mid-stream
    step(1, 1, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 1);
    // random traffic with occasional reset
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 9) < 8,
           $urandom_range(0, 2) != 0);
    $display("test done: total=%0d bad=%0d",
             n_chk, n_bad);
    $finish;
  end

endmodule
